aes_round_iter: RTL and testbench
=================================

# aes_round_iter

Iterative AES encryption round engine that sits directly downstream of the registered initial key-addition stage (round 0). It accepts the 128-bit state after the XOR with K0, applies rounds 1..NR, one round per clock, and presents the ciphertext on a valid/ready output. Round keys come from an external key schedule/store indexed by the block's round counter.

## Interface
- BLOCK_LENGTH, 128, state width; only 128 is legal.
- NR, 10, number of rounds after round 0; 10 for AES-128 and 14 for AES-256; other values are illegal.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- IN  in  BLOCK_LENGTH  state from the round-0 stage (plaintext XOR K0).
- in_valid  in  1  IN is valid this cycle.
- in_ready  out  1  block can accept IN this cycle.
- rk_idx  out  4  index of the round key required this cycle (1..NR).
- KEY  in  BLOCK_LENGTH  round key for rk_idx; combinational, same cycle.
- OUT  out  BLOCK_LENGTH  ciphertext; registered.
- out_valid  out  1  OUT holds a finished block.
- out_ready  in  1  consumer accepts OUT this cycle.

## Operation
- Byte order follows FIPS-197: IN[127:120] is state byte 0, and the state is column-major.
- The datapath reuses the team's sub_bytes, shift_rows, mix_columns and key_add blocks.
- A normal round is key_add(mix_columns(shift_rows(sub_bytes(s))), KEY).
- The final round (round == NR) omits mix_columns.
- The FSM has three states: IDLE, RUN and DONE.
  - IDLE: in_ready=1. When in_valid=1, capture IN into the state register, set round to 1 and go to RUN.
  - RUN: in_ready=0 and rk_idx=round. Each cycle, state <= round_fn(state, KEY) and round <= round+1.
  - Leaving RUN: when round == NR, apply the final round, load the result into OUT, set out_valid=1 and go to DONE.
  - DONE: out_valid=1 and OUT is held stable. If out_ready=1, clear out_valid.
  - DONE handoff: in DONE, in_ready = out_ready. If in_valid and out_ready are both 1, capture the new IN and go to RUN with round=1. If out_ready=1 and in_valid=0, go to IDLE.
- If the consumer holds out_ready=0, the block stalls in DONE indefinitely. OUT and out_valid do not change, and no new input is accepted.
- rk_idx is 0 in IDLE and DONE; the KEY input is ignored in those states.
- The round counter is 4 bits. It never exceeds NR and never wraps.
- in_valid while in RUN is ignored. The upstream stage must hold its data, because in_ready=0.

## Timing
- Reset values: OUT=0, out_valid=0, FSM=IDLE, round=0, rk_idx=0, and internal state register=0.
- in_ready is 0 while rst is low.
- Reset asserted mid-RUN or in DONE aborts the block immediately. All registers take their reset values and no partial result is ever flagged valid.
- Latency: with IN accepted at edge t, round r executes at edge t+r. out_valid rises after edge t+NR, i.e. t+10 for NR=10.
- Throughput with out_ready held at 1 and in_valid held at 1 is one block per NR+1 cycles: 11 for AES-128 and 15 for AES-256.
- A handshake completes on any rising edge where valid and ready are both 1. Neither valid depends combinationally on its own ready.
- KEY must be stable within the cycle in which rk_idx selects it. There is no KEY registering inside the block.

## Test plan
- FIPS-197 C.1, NR=10: drive IN=00102030405060708090a0b0c0d0e0f0 (00112233445566778899aabbccddeeff XOR K0) with round keys from key 000102030405060708090a0b0c0d0e0f. Required: out_valid rises 10 edges after acceptance with OUT=69c4e0d86a7b0430d8cdb78070b4c55a, and rk_idx steps 1..10 on consecutive cycles.
- Backpressure: hold out_ready=0 for 20 cycles after completion. Required: OUT and out_valid stay stable, in_ready=0, and in_valid pulses are ignored. Then raise out_ready for 1 cycle. Required: out_valid=0 on the next cycle.
- Back-to-back: keep in_valid=1 with two blocks queued and out_ready=1. Required: the second block is accepted on the same edge the first is consumed, and the outputs are spaced 11 cycles apart, both correct.
- Reset mid-operation: assert rst low at round 5. Required: OUT=0, out_valid=0 and rk_idx=0 immediately. After release, in_ready=1, and a fresh C.1 block completes correctly.
- AES-256, NR=14, FIPS-197 C.3: key 000102...1f, with IN = 00112233445566778899aabbccddeeff XOR K0. Required: OUT=8ea2b7ca516745bfeafc49904b496089 after 14 edges, and rk_idx reaches 14.
- Idle behaviour: in_valid=0 for 50 cycles after reset. Required: in_ready=1, out_valid=0 and rk_idx=0 throughout.

Source files
------------

// File: rtl/aes_round_iter.sv
// aes_round_iter: iterative AES encryption engine for rounds 1..NR.
// It takes the state after round 0 (plaintext XOR K0) and runs one round per clock.
// The round key is fetched combinationally through rk_idx.
// The ciphertext is presented on a registered valid/ready output.
module aes_round_iter #(
    parameter int BLOCK_LENGTH = 128,
    parameter int NR           = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [3:0]              rk_idx,
    input  logic [BLOCK_LENGTH-1:0] KEY,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int         NB   = BLOCK_LENGTH / 8;
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t                    fsm;
    logic [3:0]              round;
    logic [BLOCK_LENGTH-1:0] acc;
    logic [BLOCK_LENGTH-1:0] sb;
    logic [BLOCK_LENGTH-1:0] sr;
    logic [BLOCK_LENGTH-1:0] mc;
    logic [BLOCK_LENGTH-1:0] nxt;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as the affine map of the field inverse.
    // The inverse is a^254, formed as the product of a^2, a^4, ..., a^128.
    // Zero maps to zero, which is what the S-box needs.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [BLOCK_LENGTH-1:0] sub_bytes(input logic [BLOCK_LENGTH-1:0] s);
        logic [BLOCK_LENGTH-1:0] o;
        o = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            o[8*k +: 8] = sbox(s[8*k +: 8]);
        end
        return o;
    endfunction

    // State byte 4*c+r (row r, column c) sits at the top of the vector for byte 0.
    // Row r rotates left by r columns.
    function automatic logic [BLOCK_LENGTH-1:0] shift_rows(input logic [BLOCK_LENGTH-1:0] s);
        logic [BLOCK_LENGTH-1:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[8*(NB-1-(4*c+r)) +: 8] = s[8*(NB-1-(4*((c+r)%4)+r)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BLOCK_LENGTH-1:0] mix_columns(input logic [BLOCK_LENGTH-1:0] s);
        logic [BLOCK_LENGTH-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[8*(NB-1-4*c) +: 8];
            a1 = s[8*(NB-2-4*c) +: 8];
            a2 = s[8*(NB-3-4*c) +: 8];
            a3 = s[8*(NB-4-4*c) +: 8];
            o[8*(NB-1-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[8*(NB-2-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[8*(NB-3-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[8*(NB-4-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [BLOCK_LENGTH-1:0] key_add(input logic [BLOCK_LENGTH-1:0] s,
                                                        input logic [BLOCK_LENGTH-1:0] k);
        return s ^ k;
    endfunction

    // One round of the datapath; the final round skips mix_columns.
    always_comb begin
        sb  = sub_bytes(acc);
        sr  = shift_rows(sb);
        mc  = mix_columns(sr);
        nxt = key_add((round == LAST) ? sr : mc, KEY);
    end

    // round is only non-zero in RUN, so it doubles as the key index.
    assign rk_idx   = round;
    assign in_ready = rst && ((fsm == IDLE) || ((fsm == DONE) && out_ready));

    // Control FSM, state register and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= IDLE;
            round     <= '0;
            acc       <= '0;
            OUT       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= IN;
                        round <= 4'd1;
                        fsm   <= RUN;
                    end
                end
                RUN: begin
                    acc <= nxt;
                    if (round == LAST) begin
                        OUT       <= nxt;
                        out_valid <= 1'b1;
                        round     <= '0;
                        fsm       <= DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            acc   <= IN;
                            round <= 4'd1;
                            fsm   <= RUN;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_iter.sv
// Directed bench for aes_round_iter: FIPS-197 C.1 (NR=10) and C.3 (NR=14) vectors,
// backpressure, back-to-back operation, reset in mid-block, and idle behaviour.
module tb_aes_round_iter;

    localparam logic [127:0] VEC = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk;
    logic rst;

    logic [127:0] in10, key10, out10;
    logic         iv10, ir10, ov10, or10;
    logic [3:0]   rk10i;

    logic [127:0] in14, key14, out14;
    logic         iv14, ir14, ov14, or14;
    logic [3:0]   rk14i;

    logic [127:0] rks10 [0:15];
    logic [127:0] rks14 [0:15];
    logic [31:0]  w     [0:59];
    logic [7:0]   sbox_t[0:255];

    int checks;
    int errors;
    int n;

    aes_round_iter #(.BLOCK_LENGTH(128), .NR(10)) u10 (
        .clk(clk), .rst(rst), .IN(in10), .in_valid(iv10), .in_ready(ir10),
        .rk_idx(rk10i), .KEY(key10), .OUT(out10), .out_valid(ov10), .out_ready(or10)
    );

    aes_round_iter #(.BLOCK_LENGTH(128), .NR(14)) u14 (
        .clk(clk), .rst(rst), .IN(in14), .in_valid(iv14), .in_ready(ir14),
        .rk_idx(rk14i), .KEY(key14), .OUT(out14), .out_valid(ov14), .out_ready(or14)
    );

    assign key10 = rks10[rk10i];
    assign key14 = rks14[rk14i];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // S-box table built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
            sbox_t[p] = x;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nrr);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nrr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    task automatic wait_ov10(input int limit, output int cnt);
        cnt = 0;
        while (!ov10 && cnt < limit) begin
            tick();
            cnt++;
        end
        if (!ov10) cnt = -1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b0;
        in10 = '0; iv10 = 1'b0; or10 = 1'b0;
        in14 = '0; iv14 = 1'b0; or14 = 1'b0;
        for (int r = 0; r < 16; r++) begin
            rks10[r] = '0;
            rks14[r] = '0;
        end
        build_sbox();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        for (int r = 0; r <= 10; r++) rks10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        for (int r = 0; r <= 14; r++) rks14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        // Reset state
        tick();
        check("rst_out10", out10, '0);
        check("rst_flags10", 128'({ov10, ir10, rk10i}), 128'(6'b0));
        check("rst_out14", out14, '0);
        check("rst_flags14", 128'({ov14, ir14, rk14i}), 128'(6'b0));
        rst = 1'b1;
        #1;

        // Idle: 50 cycles without input
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle", 128'({ir10, ov10, rk10i}), 128'(6'b100000));
        end

        // C.1 with consumer stalled
        in10 = VEC; iv10 = 1'b1;
        tick();
        iv10 = 1'b0; in10 = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
        for (int r = 1; r <= 10; r++) begin
            check("c1_rk", 128'(rk10i), 128'(r));
            check("c1_busy", 128'({ov10, ir10}), 128'(2'b00));
            tick();
        end
        check("c1_out", out10, C1);
        check("c1_done", 128'({ov10, ir10, rk10i}), 128'(6'b100000));

        // Backpressure: 20 cycles, in_valid pulses ignored
        for (int i = 0; i < 20; i++) begin
            iv10 = (i % 3 == 0);
            tick();
            check("bp_out", out10, C1);
            check("bp_flags", 128'({ov10, ir10, rk10i}), 128'(6'b100000));
        end
        iv10 = 1'b0; or10 = 1'b1;
        #1;
        check("bp_ready", 128'(ir10), 128'(1));
        tick();
        or10 = 1'b0;
        check("bp_release", 128'({ov10, ir10, rk10i}), 128'(6'b010000));

        // Back-to-back: two blocks queued, consumer always ready
        in10 = VEC; iv10 = 1'b1; or10 = 1'b1;
        tick();
        wait_ov10(30, n);
        check("b2b_lat1", 128'(n), 128'(10));
        check("b2b_out1", out10, C1);
        check("b2b_handoff", 128'(ir10), 128'(1));
        tick();
        iv10 = 1'b0;
        check("b2b_second", 128'({ov10, rk10i}), 128'(5'b00001));
        wait_ov10(30, n);
        check("b2b_spacing", 128'(n + 1), 128'(11));
        check("b2b_out2", out10, C1);
        tick();
        check("b2b_idle", 128'({ov10, ir10}), 128'(2'b01));

        // Reset during round 5
        in10 = VEC; iv10 = 1'b1;
        tick();
        iv10 = 1'b0;
        repeat (4) tick();
        check("mid_rk5", 128'(rk10i), 128'(5));
        rst = 1'b0;
        #1;
        check("mid_rst_out", out10, '0);
        check("mid_rst_flags", 128'({ov10, ir10, rk10i}), 128'(6'b0));
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_ready", 128'(ir10), 128'(1));
        in10 = VEC; iv10 = 1'b1;
        tick();
        iv10 = 1'b0;
        wait_ov10(30, n);
        check("mid_lat", 128'(n), 128'(10));
        check("mid_out", out10, C1);
        tick();

        // AES-256, C.3
        in14 = VEC; iv14 = 1'b1; or14 = 1'b1;
        tick();
        iv14 = 1'b0;
        for (int r = 1; r <= 14; r++) begin
            check("c3_rk", 128'({ov14, rk14i}), 128'(r));
            tick();
        end
        check("c3_valid", 128'({ov14, rk14i}), 128'(5'b10000));
        check("c3_out", out14, C3);
        tick();
        check("c3_consumed", 128'({ov14, ir14}), 128'(2'b01));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
